// File: rtl/uart_receiver.sv
// 8N1 LSB-first serial receiver with oversampled 2-of-3 majority voting,
// false-start rejection, stop-bit checking and line-idle detection.
module uart_receiver #(
  parameter int ClkFrequency = 66000000,
  parameter int Baud         = 9600,
  parameter int Oversampling = 16,
  parameter int IdleBits     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_error,
  output logic       RxD_busy,
  output logic       RxD_idle
);

  localparam int Div     = (ClkFrequency + Baud * Oversampling / 2) / (Baud * Oversampling);
  localparam int DivW    = (Div > 1) ? $clog2(Div) : 1;
  localparam int OsW     = $clog2(Oversampling);
  localparam int Half    = Oversampling / 2;
  localparam int IdleMax = IdleBits * Oversampling;
  localparam int IdleW   = $clog2(IdleMax + 1);

  if (Div < 1) begin : gBadDiv
    $error("uart_receiver: ClkFrequency too low for Baud * Oversampling");
  end
  if (Oversampling != 8 && Oversampling != 16) begin : gBadOs
    $error("uart_receiver: Oversampling must be 8 or 16");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rxState_t;

  rxState_t state, stateNext;

  logic             rxdSync, rxdS;
  logic [DivW-1:0]  divCnt;
  logic [OsW-1:0]   osCnt;
  logic [IdleW-1:0] idleCnt;
  logic [2:0]       vote;
  logic [7:0]       shreg;
  logic [2:0]       bitIdx;

  logic tick, osMid, osLast;
  logic voteNow, voteAll;
  logic startDet, shiftEn, loadData, frameErr;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign tick   = (divCnt == DivW'(Div - 1));
  assign osMid  = tick && (osCnt == OsW'(Half));
  assign osLast = tick && (osCnt == OsW'(Oversampling - 1));

  // At the third sample point the third vote is still on the line, so it is
  // taken directly from rxdS rather than from the sample register.
  assign voteNow = maj3(vote[0], vote[1], rxdS);
  assign voteAll = maj3(vote[0], vote[1], vote[2]);

  assign RxD_busy = (state != IDLE);
  assign RxD_idle = (idleCnt == IdleW'(IdleMax));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    stateNext = state;
    startDet  = 1'b0;
    shiftEn   = 1'b0;
    loadData  = 1'b0;
    frameErr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxdS) begin
          stateNext = START;
          startDet  = 1'b1;
        end
      end
      START: begin
        if (osMid && voteNow) stateNext = IDLE;
        else if (osLast)      stateNext = DATA;
      end
      DATA: begin
        if (osLast) begin
          shiftEn = 1'b1;
          if (bitIdx == 3'd7) stateNext = STOP;
        end
      end
      STOP: begin
        // Decided half a bit early so a back-to-back start edge is not missed.
        if (osMid) begin
          if (voteNow) begin
            loadData  = 1'b1;
            stateNext = IDLE;
          end else begin
            frameErr  = 1'b1;
            stateNext = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxdS) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxdSync         <= 1'b1;
      rxdS            <= 1'b1;
      divCnt          <= '0;
      osCnt           <= '0;
      idleCnt         <= '0;
      vote            <= '0;
      shreg           <= '0;
      bitIdx          <= '0;
      RxD_data        <= '0;
      RxD_data_ready  <= 1'b0;
      RxD_frame_error <= 1'b0;
    end else begin
      rxdSync <= RxD;
      rxdS    <= rxdSync;

      // Realign bit timing to the detected start edge.
      if (startDet) begin
        divCnt <= '0;
        osCnt  <= '0;
        bitIdx <= '0;
      end else begin
        divCnt <= tick ? '0 : divCnt + DivW'(1);
        if (tick) osCnt <= osCnt + OsW'(1);
      end

      if (tick) begin
        if (osCnt == OsW'(Half - 2)) vote[0] <= rxdS;
        if (osCnt == OsW'(Half - 1)) vote[1] <= rxdS;
        if (osCnt == OsW'(Half))     vote[2] <= rxdS;
      end

      if (shiftEn) begin
        shreg  <= {voteAll, shreg[7:1]};
        bitIdx <= bitIdx + 3'd1;
      end

      if (loadData) RxD_data <= shreg;
      RxD_data_ready  <= loadData;
      RxD_frame_error <= frameErr;

      if (state != IDLE || !rxdS)
        idleCnt <= '0;
      else if (tick && !RxD_idle)
        idleCnt <= idleCnt + IdleW'(1);
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: hand-written corner cases, a vector
// table and randomized frames scored against a frame-level reference model.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_frame_error;
  logic       RxD_busy;
  logic       RxD_idle;

  uart_receiver #(
    .ClkFrequency(1600000),
    .Baud        (100000),
    .Oversampling(16),
    .IdleBits    (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .RxD            (RxD),
    .RxD_data       (RxD_data),
    .RxD_data_ready (RxD_data_ready),
    .RxD_frame_error(RxD_frame_error),
    .RxD_busy       (RxD_busy),
    .RxD_idle       (RxD_idle)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: counts posedges and records every strobe and busy/idle edge.
  int cyc = 0;
  int readyCnt = 0, errCnt = 0, overlapCnt = 0, wideCnt = 0;
  int readyCyc = 0, busyRiseCyc = 0, busyFallCyc = 0, idleFallCyc = 0;
  logic prevBusy = 1'b0, prevIdle = 1'b0, prevReady = 1'b0, prevErr = 1'b0;
  int         evKind[$];
  logic [7:0] evData[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (RxD_data_ready) begin
        readyCnt <= readyCnt + 1;
        readyCyc <= cyc;
        evKind.push_back(0);
        evData.push_back(RxD_data);
      end
      if (RxD_frame_error) begin
        errCnt <= errCnt + 1;
        evKind.push_back(1);
        evData.push_back(RxD_data);
      end
      if (RxD_data_ready && RxD_frame_error) overlapCnt <= overlapCnt + 1;
      if ((RxD_data_ready && prevReady) || (RxD_frame_error && prevErr)) wideCnt <= wideCnt + 1;
      if (RxD_busy && !prevBusy) busyRiseCyc <= cyc;
      if (!RxD_busy && prevBusy) busyFallCyc <= cyc;
      if (!RxD_idle && prevIdle) idleFallCyc <= cyc;
    end
    prevBusy  <= RxD_busy;
    prevIdle  <= RxD_idle;
    prevReady <= RxD_data_ready;
    prevErr   <= RxD_frame_error;
  end

  // One slot = one clk: the value driven here is sampled at the next posedge.
  task automatic slot(input logic v);
    RxD = v;
    @(negedge clk);
  endtask

  task automatic idleSlots(input int n);
    repeat (n) slot(1'b1);
  endtask

  int startCyc = 0;

  // Drives one 8N1 frame whose bit length is lenX100/100 clk. With noisy set
  // (nominal 16-clk bits only) one of the three mid-bit vote slots of every
  // data bit is inverted. rstSlot >= 0 pulses rst for two slots there.
  task automatic sendFrame(input logic [7:0] d, input logic stopv, input int lenX100,
                           input bit noisy, input int rstSlot);
    int nSlots;
    nSlots = (10 * lenX100 + 99) / 100;
    for (int t = 0; t < nSlots; t++) begin
      int   b;
      logic v;
      b = (t * 100) / lenX100;
      if (b == 0)      v = 1'b0;
      else if (b <= 8) v = d[b-1];
      else             v = stopv;
      if (noisy && b >= 1 && b <= 8 && (t % 16) == 7 + ((b - 1) % 3)) v = ~v;
      if (t == 0) startCyc = cyc;
      rst = (rstSlot >= 0 && (t == rstSlot || t == rstSlot + 1));
      slot(v);
    end
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stopv;
    int         lenX100;
    bit         expReady;
    bit         expErr;
    logic [7:0] expData;
  } vec_t;

  vec_t       vecs[7];
  int         r0, e0;
  logic [7:0] modelLast;
  int         expKind[$];
  logic [7:0] expData[$];

  initial begin
    vecs = '{
      '{8'h00, 1'b1, 1600, 1'b1, 1'b0, 8'h00},
      '{8'hFF, 1'b1, 1648, 1'b1, 1'b0, 8'hFF},
      '{8'h3C, 1'b0, 1600, 1'b0, 1'b1, 8'hFF},
      '{8'h81, 1'b1, 1552, 1'b1, 1'b0, 8'h81},
      '{8'h01, 1'b1, 1600, 1'b1, 1'b0, 8'h01},
      '{8'h80, 1'b0, 1648, 1'b0, 1'b1, 8'h01},
      '{8'h7E, 1'b1, 1552, 1'b1, 1'b0, 8'h7E}
    };

    // Reset state and idle detection.
    RxD = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", RxD_data, 8'h00);
    check("rst_ready", RxD_data_ready, 1'b0);
    check("rst_ferr", RxD_frame_error, 1'b0);
    check("rst_busy", RxD_busy, 1'b0);
    check("rst_idle", RxD_idle, 1'b0);
    rst = 1'b0;
    repeat (159) @(negedge clk);
    check("idle_before_160", RxD_idle, 1'b0);
    @(negedge clk);
    check("idle_at_160", RxD_idle, 1'b1);
    idleSlots(5);
    modelLast = 8'h00;

    // Single byte with exact latency.
    r0 = readyCnt;
    e0 = errCnt;
    sendFrame(8'hA5, 1'b1, 1600, 1'b0, -1);
    idleSlots(4);
    check("sb_ready_count", readyCnt - r0, 1);
    check("sb_err_count", errCnt - e0, 0);
    check("sb_data", RxD_data, 8'hA5);
    check("sb_ready_edge", readyCyc - startCyc - 1, 155);
    check("sb_busy_rise_edge", busyRiseCyc - startCyc - 1, 2);
    check("sb_busy_fall_with_ready", busyFallCyc, readyCyc);
    check("sb_idle_fall_edge", idleFallCyc - startCyc - 1, 2);
    modelLast = 8'hA5;

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      r0 = readyCnt;
      e0 = errCnt;
      sendFrame(vecs[i].data, vecs[i].stopv, vecs[i].lenX100, 1'b0, -1);
      idleSlots(6);
      check($sformatf("vec%0d_ready", i), readyCnt - r0, 32'(vecs[i].expReady));
      check($sformatf("vec%0d_ferr", i), errCnt - e0, 32'(vecs[i].expErr));
      check($sformatf("vec%0d_data", i), RxD_data, vecs[i].expData);
      if (vecs[i].expReady) modelLast = vecs[i].data;
    end

    // Back-to-back frames, each bit 3% long.
    idleSlots(10);
    evKind.delete();
    evData.delete();
    sendFrame(8'h00, 1'b1, 1648, 1'b0, -1);
    sendFrame(8'hFF, 1'b1, 1648, 1'b0, -1);
    sendFrame(8'h55, 1'b1, 1648, 1'b0, -1);
    idleSlots(6);
    check("b2b_count", evKind.size(), 3);
    if (evKind.size() >= 3) begin
      check("b2b_kinds", evKind[0] + evKind[1] + evKind[2], 0);
      check("b2b_data0", evData[0], 8'h00);
      check("b2b_data1", evData[1], 8'hFF);
      check("b2b_data2", evData[2], 8'h55);
    end
    modelLast = 8'h55;

    // False start: 4-clk glitch.
    idleSlots(10);
    r0 = readyCnt;
    e0 = errCnt;
    startCyc = cyc;
    repeat (4) slot(1'b0);
    idleSlots(30);
    check("fs_ready", readyCnt - r0, 0);
    check("fs_ferr", errCnt - e0, 0);
    check("fs_busy_rose", busyRiseCyc > startCyc, 1'b1);
    check("fs_busy_fall_within_11", (busyFallCyc - startCyc - 1) <= 11, 1'b1);
    check("fs_busy_now", RxD_busy, 1'b0);

    // Framing error followed by a held-low line, then recovery.
    r0 = readyCnt;
    e0 = errCnt;
    sendFrame(8'h3C, 1'b0, 1600, 1'b0, -1);
    repeat (40) slot(1'b0);
    idleSlots(10);
    check("fe_err_count", errCnt - e0, 1);
    check("fe_ready_count", readyCnt - r0, 0);
    check("fe_data_held", RxD_data, modelLast);
    r0 = readyCnt;
    sendFrame(8'h81, 1'b1, 1600, 1'b0, -1);
    idleSlots(6);
    check("fe_recover_count", readyCnt - r0, 1);
    check("fe_recover_data", RxD_data, 8'h81);
    modelLast = 8'h81;

    // One corrupted vote sample per data bit.
    r0 = readyCnt;
    sendFrame(8'h96, 1'b1, 1600, 1'b1, -1);
    idleSlots(6);
    check("noise_count", readyCnt - r0, 1);
    check("noise_data", RxD_data, 8'h96);
    modelLast = 8'h96;

    // Reset in the middle of data bit 4; remaining line stays high.
    r0 = readyCnt;
    e0 = errCnt;
    sendFrame(8'hF0, 1'b1, 1600, 1'b0, 16 * 5 + 8);
    idleSlots(100);
    check("rstmid_ready", readyCnt - r0, 0);
    check("rstmid_ferr", errCnt - e0, 0);
    check("rstmid_data", RxD_data, 8'h00);
    r0 = readyCnt;
    sendFrame(8'h5A, 1'b1, 1600, 1'b0, -1);
    idleSlots(6);
    check("rstmid_next_count", readyCnt - r0, 1);
    check("rstmid_next_data", RxD_data, 8'h5A);
    modelLast = 8'h5A;

    // Randomized frames against a frame-level model: good stop delivers the
    // byte, bad stop reports an error with the last good byte still shown.
    idleSlots(10);
    evKind.delete();
    evData.delete();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      bit         good;
      int         len, gap;
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 7) != 0);
      len  = int'($urandom_range(1552, 1648));
      gap  = good ? int'($urandom_range(0, 8)) : int'($urandom_range(3, 10));
      sendFrame(d, good, len, 1'b0, -1);
      idleSlots(gap);
      if (good) begin
        modelLast = d;
        expKind.push_back(0);
      end else begin
        expKind.push_back(1);
      end
      expData.push_back(modelLast);
    end
    idleSlots(10);
    check("rand_event_count", evKind.size(), expKind.size());
    for (int i = 0; i < expKind.size() && i < evKind.size(); i++) begin
      check($sformatf("rand%0d_kind", i), evKind[i], expKind[i]);
      check($sformatf("rand%0d_data", i), evData[i], expData[i]);
    end

    check("no_ready_ferr_overlap", overlapCnt, 0);
    check("strobes_one_cycle", wideCnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
